// File: rtl/cordic_pkg.sv
// Constants and replay FSM encoding shared by the CORDIC direction-bit blocks.
package cordic_pkg;

    localparam int ITER_DEF = 14;
    localparam int BITNUM   = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2
    } rep_state_e;

endpackage

// File: rtl/dir_fifo.sv
// Angle-word FIFO with registered storage, wrap-around pointers and occupancy count.
module dir_fifo #(
    parameter  int WIDTH = 14,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO only lands when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cordic_dir_buf.sv
// Captures vectoring-CORDIC direction bits into angle words and replays them
// serially to a rotation CORDIC, each word REPLAY times before it is popped.
module cordic_dir_buf
    import cordic_pkg::*;
#(
    parameter  int ITER   = ITER_DEF,
    parameter  int DEPTH  = 4,
    parameter  int REPLAY = 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_start_i,
    input  logic             cap_d_i,
    input  logic             rep_req_i,
    output logic             rot_start_o,
    output logic             rot_d_o,
    output logic             busy_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    localparam int              IDX_W       = $clog2(ITER);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ITER - 1);
    localparam logic [3:0]       REPLAY_LAST = 4'(REPLAY - 1);

    rep_state_e        state_q, state_d;
    logic              cap_arm_q, cap_arm_d;
    logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
    logic [ITER-1:0]   cap_word_q, cap_word_d, cap_word_s;
    logic [IDX_W-1:0]  bit_q, bit_d;
    logic [3:0]        rep_cnt_q, rep_cnt_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;
    logic [ITER-1:0]   head_word;

    dir_fifo #(
        .WIDTH (ITER),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (cap_word_s),
        .pop_i       (pop),
        .head_o      (head_word),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o)
    );

    // A fresh start pulse discards any partial word; a word completing on that
    // same edge is still pushed because all its bits are already in.
    always_comb begin
        cap_arm_d  = cap_arm_q;
        cap_idx_d  = cap_idx_q;
        cap_word_s = cap_word_q;
        push       = 1'b0;
        if (cap_arm_q) begin
            cap_word_s[cap_idx_q] = cap_d_i;
            if (cap_idx_q == LAST_IDX) begin
                push      = 1'b1;
                cap_arm_d = 1'b0;
            end else begin
                cap_idx_d = cap_idx_q + 1'b1;
            end
        end
        cap_word_d = cap_word_s;
        if (cap_start_i) begin
            cap_arm_d  = 1'b1;
            cap_idx_d  = '0;
            cap_word_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        rep_cnt_d   = rep_cnt_q;
        pop         = 1'b0;
        rot_start_o = 1'b0;
        rot_d_o     = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rep_req_i && !empty_o) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                rot_start_o = 1'b1;
                busy_o      = 1'b1;
                bit_d       = '0;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy_o  = 1'b1;
                rot_d_o = head_word[bit_q];
                if (bit_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    if (rep_cnt_q == REPLAY_LAST) begin
                        pop       = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign overflow_d = overflow_q | (push && full_o && !pop);
    assign overflow_o = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cap_arm_q  <= 1'b0;
            cap_idx_q  <= '0;
            cap_word_q <= '0;
            bit_q      <= '0;
            rep_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_arm_q  <= cap_arm_d;
            cap_idx_q  <= cap_idx_d;
            cap_word_q <= cap_word_d;
            bit_q      <= bit_d;
            rep_cnt_q  <= rep_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_cordic_dir_buf.sv
// Drives two buffers (REPLAY=1 and REPLAY=3) with shared stimulus and compares
// every output each cycle against a word-list reference model.
module tb_cordic_dir_buf;

    localparam int ITER  = 14;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cap_start, cap_d, rep_req;
    logic [1:0] rot_start, rot_d, busy, full, empty, ovf;
    logic [2:0] cnt0, cnt1;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Reference model: per instance, an ordered word list plus a replay countdown.
    int          m_cnt  [2];
    logic [13:0] m_q    [2][DEPTH];
    bit          m_ovf  [2];
    int          m_left [2];
    int          m_seen [2];
    int          m_n;
    logic [13:0] m_word;

    always #5 clk = ~clk;

    cordic_dir_buf #(.ITER(ITER), .DEPTH(DEPTH), .REPLAY(1)) dut_r1 (
        .clk(clk), .rst(rst), .cap_start_i(cap_start), .cap_d_i(cap_d),
        .rep_req_i(rep_req), .rot_start_o(rot_start[0]), .rot_d_o(rot_d[0]),
        .busy_o(busy[0]), .full_o(full[0]), .empty_o(empty[0]),
        .count_o(cnt0), .overflow_o(ovf[0])
    );

    cordic_dir_buf #(.ITER(ITER), .DEPTH(DEPTH), .REPLAY(3)) dut_r3 (
        .clk(clk), .rst(rst), .cap_start_i(cap_start), .cap_d_i(cap_d),
        .rep_req_i(rep_req), .rot_start_o(rot_start[1]), .rot_d_o(rot_d[1]),
        .busy_o(busy[1]), .full_o(full[1]), .empty_o(empty[1]),
        .count_o(cnt1), .overflow_o(ovf[1])
    );

    function automatic int repl(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n    = -1;
        m_word = '0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_ovf[i]  = 1'b0;
            m_left[i] = 0;
            m_seen[i] = 0;
        end
    endtask

    task automatic model_step();
        bit          push_w;
        bit          pop_w;
        logic [13:0] pw;
        push_w = 1'b0;
        pw     = '0;
        if (m_n >= 0) begin
            m_word[m_n] = cap_d;
            m_n++;
            if (m_n == ITER) begin
                push_w = 1'b1;
                pw     = m_word;
                m_n    = -1;
            end
        end
        if (cap_start) begin
            m_n    = 0;
            m_word = '0;
        end
        for (int i = 0; i < 2; i++) begin
            pop_w = 1'b0;
            if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_seen[i]++;
                    if (m_seen[i] == repl(i)) begin
                        pop_w     = 1'b1;
                        m_seen[i] = 0;
                    end
                end
            end else if (rep_req && m_cnt[i] > 0) begin
                m_left[i] = ITER + 1;
            end
            if (pop_w) begin
                for (int k = 0; k < DEPTH - 1; k++) m_q[i][k] = m_q[i][k+1];
                m_cnt[i]--;
            end
            if (push_w) begin
                if (m_cnt[i] < DEPTH) begin
                    m_q[i][m_cnt[i]] = pw;
                    m_cnt[i]++;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        int exp_d;
        for (int i = 0; i < 2; i++) begin
            exp_d = 0;
            if (m_left[i] >= 1 && m_left[i] <= ITER) exp_d = int'(m_q[i][0][ITER - m_left[i]]);
            chk($sformatf("start%0d", i), int'(rot_start[i]), int'(m_left[i] == ITER + 1));
            chk($sformatf("dbit%0d", i), int'(rot_d[i]), exp_d);
            chk($sformatf("busy%0d", i), int'(busy[i]), int'(m_left[i] > 0));
            chk($sformatf("count%0d", i), (i == 0) ? int'(cnt0) : int'(cnt1), m_cnt[i]);
            chk($sformatf("full%0d", i), int'(full[i]), int'(m_cnt[i] == DEPTH));
            chk($sformatf("empty%0d", i), int'(empty[i]), int'(m_cnt[i] == 0));
            chk($sformatf("ovf%0d", i), int'(ovf[i]), int'(m_ovf[i]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        cap_start = 1'b0;
        cap_d     = 1'b0;
        rep_req   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic capture(input logic [13:0] w);
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        for (int b = 0; b < ITER; b++) begin
            cap_d = w[b];
            tick();
        end
        cap_d = 1'b0;
    endtask

    task automatic replay_collect(input int inst, output logic [13:0] w, output int starts);
        w       = '0;
        starts  = 0;
        rep_req = 1'b1;
        tick();
        rep_req = 1'b0;
        starts += int'(rot_start[inst]);
        for (int k = 0; k < ITER; k++) begin
            tick();
            w[k] = rot_d[inst];
            starts += int'(rot_start[inst]);
        end
        tick();
        starts += int'(rot_start[inst]);
    endtask

    logic [13:0] words [5];
    logic [13:0] got;
    int          starts;

    initial begin
        rst       = 1'b1;
        cap_start = 1'b0;
        cap_d     = 1'b0;
        rep_req   = 1'b0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single word captured and replayed once on the REPLAY=1 instance.
        capture(14'h2A5C);
        replay_collect(0, got, starts);
        chk("stream_2a5c", int'(got), 32'h2A5C);
        chk("one_start", starts, 1);
        chk("empty_after", int'(empty[0]), 1);

        // REPLAY=3 instance keeps the word until its third replay.
        replay_collect(1, got, starts);
        chk("r3_stream2", int'(got), 32'h2A5C);
        chk("r3_cnt_kept", int'(cnt1), 1);
        replay_collect(1, got, starts);
        chk("r3_stream3", int'(got), 32'h2A5C);
        chk("r3_cnt_zero", int'(cnt1), 0);

        // Five captures into a four-deep FIFO: last one is dropped.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            words[k] = 14'($urandom);
            capture(words[k]);
        end
        chk("ovf_full", int'(full[0]), 1);
        chk("ovf_flag", int'(ovf[0]), 1);
        chk("ovf_count", int'(cnt0), 4);
        for (int k = 0; k < 4; k++) begin
            replay_collect(0, got, starts);
            chk($sformatf("ovf_word%0d", k), int'(got), int'(words[k]));
        end

        // Full FIFO: capture completes on the very edge the head is popped.
        apply_reset();
        for (int k = 0; k < 5; k++) words[k] = 14'($urandom);
        for (int k = 0; k < 4; k++) capture(words[k]);
        rep_req = 1'b1;
        tick();
        rep_req = 1'b0;
        capture(words[4]);
        chk("simul_count", int'(cnt0), 4);
        chk("simul_ovf", int'(ovf[0]), 0);
        for (int k = 1; k < 5; k++) begin
            replay_collect(0, got, starts);
            chk($sformatf("simul_word%0d", k), int'(got), int'(words[k]));
        end

        // Restart at bit 7 discards the partial word.
        apply_reset();
        words[0]  = 14'($urandom);
        words[1]  = 14'($urandom);
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        for (int b = 0; b < 7; b++) begin
            cap_d = words[0][b];
            tick();
        end
        capture(words[1]);
        chk("restart_count", int'(cnt0), 1);
        replay_collect(0, got, starts);
        chk("restart_word", int'(got), int'(words[1]));

        // Reset in the middle of a shift.
        capture(14'($urandom));
        rep_req = 1'b1;
        tick();
        rep_req = 1'b0;
        repeat (5) tick();
        apply_reset();
        chk("rst_empty", int'(empty[0]), 1);
        chk("rst_busy", int'(busy[0]), 0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cap_start = ($urandom_range(0, 19) == 0);
            cap_d     = 1'($urandom);
            rep_req   = ($urandom_range(0, 3) == 0);
            tick();
        end
        cap_start = 1'b0;
        rep_req   = 1'b0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/cordic_dir_buf.md
CORDIC_DIR_BUF -- requirements
Module: cordic_dir_buf

Interface
REQ-001 SHALL have parameter ITER, default 14: number of CORDIC micro-rotations, i.e. direction bits per angle.
REQ-002 SHALL have parameter DEPTH, default 4: number of angles buffered; a power of two, 2..16.
REQ-003 SHALL have parameter REPLAY, default 1: number of times each stored angle is replayed before it is popped; range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cap_start_i, input, 1 bit: one-cycle pulse coincident with the start pulse of the upstream vectoring CORDIC.
REQ-007 SHALL have port cap_d_i, input, 1 bit: serial direction bit from the vectoring CORDIC d_o.
REQ-008 SHALL have port rep_req_i, input, 1 bit: request to replay the oldest angle.
REQ-009 SHALL have port rot_start_o, output, 1 bit: start pulse to the downstream rotation CORDIC.
REQ-010 SHALL have port rot_d_o, output, 1 bit: serial direction bit to the rotation CORDIC d_i.
REQ-011 SHALL have port busy_o, output, 1 bit: replay in progress.
REQ-012 SHALL have port full_o, output, 1 bit; port empty_o, output, 1 bit; and port count_o, output, clog2(DEPTH+1) bits: FIFO status and occupancy.
REQ-013 SHALL have port overflow_o, output, 1 bit: sticky flag set when an angle is dropped.

Function
REQ-014 Capture: a cap_start_i at edge t SHALL arm capture; cap_d_i sampled at edges t+1..t+ITER SHALL form bits 0..ITER-1 of one angle word, with bit 0 being the first iteration.
REQ-015 The completed word SHALL be pushed at edge t+ITER; count_o and empty_o SHALL reflect the push in cycle t+ITER+1.
REQ-016 A cap_start_i arriving mid-capture SHALL discard the partial word and restart capture from bit 0, with no push and no flag.
REQ-017 A push when full with no pop in the same cycle SHALL drop the word, set overflow_o, and leave FIFO contents unchanged; overflow_o SHALL clear only on reset.
REQ-018 Replay FSM states SHALL be IDLE, START and SHIFT.
REQ-019 IDLE to START SHALL occur when rep_req_i=1 and empty_o=0 at an edge; rep_req_i while empty or busy SHALL be ignored without queueing.
REQ-020 START SHALL last one cycle with rot_start_o=1, then transition to SHIFT.
REQ-021 SHIFT SHALL last ITER cycles, driving rot_d_o = head word bit k in its k-th cycle (k=0..ITER-1), so bit 0 is valid in the cycle after rot_start_o.
REQ-022 At the end of SHIFT the replay counter SHALL increment; if it reaches REPLAY the head SHALL be popped and the counter cleared; the FSM SHALL then return to IDLE.
REQ-023 busy_o SHALL be 1 in START and SHIFT; rot_d_o and rot_start_o SHALL be 0 in IDLE.
REQ-024 Simultaneous push and pop SHALL both take effect with count unchanged, including when full; an overflow in this case is not possible.
REQ-025 Pointers SHALL wrap modulo DEPTH; count_o SHALL range 0..DEPTH, with full_o = (count_o==DEPTH) and empty_o = (count_o==0).
REQ-026 The head word SHALL remain stable throughout a replay regardless of concurrent pushes.

Reset
REQ-027 Asserting rst SHALL immediately force FSM=IDLE, capture disarmed, pointers, count and replay counter to 0, and all storage to 0.
REQ-028 While rst is asserted, outputs SHALL be rot_start_o=0, rot_d_o=0, busy_o=0, full_o=0, empty_o=1, count_o=0, overflow_o=0.
REQ-029 A reset mid-capture or mid-replay SHALL abandon the operation with no push and no pop.

Structure
REQ-030 ITER default, BITNUM=18 and the FSM state encoding SHALL reside in the shared package cordic_pkg.
REQ-031 Storage SHALL be a single sub-module dir_fifo (width ITER, depth DEPTH, with push/pop/full/empty/count); capture shifter and replay FSM SHALL reside in cordic_dir_buf.

Verification
REQ-032 Capture then replay: capture word 14'h2A5C, then rep_req_i -> rot_start_o pulses once, rot_d_o emits 0,0,1,1,1,0,1,0,0,1,0,1,0,1 on the 14 following cycles, and empty_o=1 afterwards.
REQ-033 Overflow: capture 5 words with DEPTH=4 -> full_o=1, overflow_o=1, count_o=4; replays return words 1..4 in order.
REQ-034 Replay count: with REPLAY=3 and one word captured, 3 requests -> 3 identical 14-bit streams; count_o drops to 0 only after the third.
REQ-035 Simultaneous events: with FIFO full, a capture completes on the same edge as a replay pop -> count_o stays 4, overflow_o=0, and the new word is returned last.
REQ-036 Restart and reset: cap_start_i re-pulsed at bit 7 -> only the second word is stored; rst asserted mid-SHIFT -> outputs go to reset values immediately and empty_o=1.
